// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: fetch/decode/execute FSM driving one shared ROM/RAM bus with wait states.
// Optional carry flag for ADD (and SKZ on carry) is built when ACC_CPU_CARRY_EN is defined.
module acc_cpu_core #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 5,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  output logic              wr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata,
  input  logic              mem_ready,
  output logic              halt,
  output logic              fetch,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] ir_addr,
`ifdef ACC_CPU_CARRY_EN
  output logic              carry,
`endif
  output logic [ADDR_W-1:0] pc_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_WRITE, S_HALT
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Only the opcode and operand fields of the instruction word are kept.
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [ADDR_W+2:0]   ir_q, ir_d;
  logic [2:0]          op_w;
  logic [ADDR_W-1:0]   operand_w;
  logic                skip_w;
`ifdef ACC_CPU_CARRY_EN
  logic                carry_q, carry_d;
  logic [DATA_W:0]     sum_w;
  assign sum_w  = {1'b0, acc_q} + {1'b0, rdata};
  assign skip_w = (acc_q == '0) || carry_q;
  assign carry  = carry_q;
`else
  assign skip_w = (acc_q == '0);
`endif

  assign op_w      = ir_q[ADDR_W+2 -: 3];
  assign operand_w = ir_q[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
`ifdef ACC_CPU_CARRY_EN
    carry_d = carry_q;
`endif
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) begin
        ir_d    = {rdata[DATA_W-1 -: 3], rdata[ADDR_W-1:0]};
        pc_d    = pc_q + PC_ONE;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op_w)
          OP_HLT: state_d = S_HALT;
          OP_SKZ: begin
            if (skip_w) pc_d = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = operand_w;
            state_d = S_FETCH;
          end
          OP_STO:  state_d = S_WRITE;
          default: state_d = S_READ;
        endcase
      end
      S_READ: if (mem_ready) begin
        case (op_w)
`ifdef ACC_CPU_CARRY_EN
          OP_ADD:  begin acc_d = sum_w[DATA_W-1:0]; carry_d = sum_w[DATA_W]; end
          OP_AND:  begin acc_d = acc_q & rdata; carry_d = 1'b0; end
          OP_XOR:  begin acc_d = acc_q ^ rdata; carry_d = 1'b0; end
          default: begin acc_d = rdata; carry_d = 1'b0; end
`else
          OP_ADD:  acc_d = acc_q + rdata;
          OP_AND:  acc_d = acc_q & rdata;
          OP_XOR:  acc_d = acc_q ^ rdata;
          default: acc_d = rdata;
`endif
        endcase
        state_d = S_FETCH;
      end
      S_WRITE: if (mem_ready) state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      acc_q   <= '0;
      ir_q    <= '0;
`ifdef ACC_CPU_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
`ifdef ACC_CPU_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  // Bus strobes come straight from the state register so reset drops them asynchronously.
  always_comb begin
    addr  = '0;
    rd    = 1'b0;
    wr    = 1'b0;
    fetch = 1'b0;
    halt  = 1'b0;
    case (state_q)
      S_FETCH: begin addr = pc_q; rd = 1'b1; fetch = 1'b1; end
      S_READ:  begin addr = operand_w; rd = 1'b1; end
      S_WRITE: begin addr = operand_w; wr = 1'b1; end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

  assign wdata   = acc_q;
  assign opcode  = op_w;
  assign ir_addr = operand_w;
  assign pc_addr = pc_q;

endmodule
